// File: rtl/gpio_irq_scheduler_if.sv
// rtl/gpio_irq_scheduler_if.sv - GPIO interrupt scheduler bus: controller status, CPU handshake, clear request
interface gpio_irq_scheduler_if #(
    parameter int NUM_PINS  = 32,
    parameter int ID_W      = $clog2(NUM_PINS),
    parameter int HOLDOFF_W = 8
);
    logic [NUM_PINS-1:0]  irq_status;
    logic [NUM_PINS-1:0]  cfg_mask;
    logic [HOLDOFF_W-1:0] cfg_holdoff;
    logic                 cpu_claim;
    logic                 cpu_complete;
    logic                 cpu_irq;
    logic [ID_W-1:0]      claim_id;
    logic                 clr_valid;
    logic [NUM_PINS-1:0]  clr_mask;
    logic                 clr_ready;
    logic                 busy;

    modport slave (
        input  irq_status, cfg_mask, cfg_holdoff, cpu_claim, cpu_complete, clr_ready,
        output cpu_irq, claim_id, clr_valid, clr_mask, busy
    );

    modport master (
        output irq_status, cfg_mask, cfg_holdoff, cpu_claim, cpu_complete, clr_ready,
        input  cpu_irq, claim_id, clr_valid, clr_mask, busy
    );
endinterface

// File: rtl/gpio_irq_scheduler.sv
// rtl/gpio_irq_scheduler.sv - round-robin GPIO interrupt sequencer with claim/complete and W1C clear
module gpio_irq_scheduler #(
    parameter int NUM_PINS  = 32,
    parameter int ID_W      = $clog2(NUM_PINS),
    parameter int HOLDOFF_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    gpio_irq_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_NOTIFY,
        S_SERVICE,
        S_CLEAR
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_sel_id;
    logic [HOLDOFF_W-1:0] r_hold_cnt;

    logic [NUM_PINS-1:0]  w_pending;
    logic                 w_hi_found;
    logic [ID_W-1:0]      w_hi_id;
    logic [ID_W-1:0]      w_lo_id;
    logic [ID_W-1:0]      w_rr_sel;
    logic                 w_clr_fire;

    assign w_pending  = bus.irq_status & bus.cfg_mask;
    assign w_clr_fire = (r_state == S_CLEAR) && bus.clr_ready;

    // Round-robin pick: lowest pending at/above the pointer, else wrap to the lowest pending overall
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_lo_id = ID_W'(i);
                if (ID_W'(i) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = ID_W'(i);
                end
            end
        end
        w_rr_sel = w_hi_found ? w_hi_id : w_lo_id;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; claim wins over a same-cycle withdrawal in NOTIFY
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_hold_cnt == '0) && (|w_pending)) begin
                    w_next_state = S_ARB;
                end
            end
            S_ARB: begin
                w_next_state = (|w_pending) ? S_NOTIFY : S_IDLE;
            end
            S_NOTIFY: begin
                if (bus.cpu_claim) begin
                    w_next_state = S_SERVICE;
                end else if (!w_pending[r_sel_id]) begin
                    w_next_state = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (bus.cpu_complete) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (bus.clr_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Selection, round-robin pointer and hold-off counter; pointer/hold-off only move on a completed clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_sel_id   <= '0;
            r_hold_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            if ((r_state == S_ARB) && (|w_pending)) begin
                r_sel_id <= w_rr_sel;
            end
            if (w_clr_fire) begin
                r_rr_ptr   <= (r_sel_id == ID_W'(NUM_PINS - 1)) ? '0 : r_sel_id + 1'b1;
                r_hold_cnt <= bus.cfg_holdoff;
            end
        end
    end

    assign bus.cpu_irq   = (r_state == S_NOTIFY);
    assign bus.claim_id  = r_sel_id;
    assign bus.clr_valid = (r_state == S_CLEAR);
    assign bus.clr_mask  = (r_state == S_CLEAR) ? ({{(NUM_PINS-1){1'b0}}, 1'b1} << r_sel_id) : '0;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_gpio_irq_scheduler.sv
// tb/tb_gpio_irq_scheduler.sv - directed self-checking bench for gpio_irq_scheduler
module tb_gpio_irq_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gpio_irq_scheduler_if #(.NUM_PINS(32), .ID_W(5), .HOLDOFF_W(8)) bus ();

    gpio_irq_scheduler #(.NUM_PINS(32), .ID_W(5), .HOLDOFF_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (bus.cpu_irq === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic do_service();
        bus.cpu_claim = 1'b1;
        step();
        bus.cpu_claim    = 1'b0;
        bus.cpu_complete = 1'b1;
        step();
        bus.cpu_complete = 1'b0;
        bus.clr_ready    = 1'b1;
        step();
        bus.clr_ready = 1'b0;
    endtask

    task automatic apply_reset();
        bus.irq_status   = '0;
        bus.cfg_mask     = '1;
        bus.cfg_holdoff  = '0;
        bus.cpu_claim    = 1'b0;
        bus.cpu_complete = 1'b0;
        bus.clr_ready    = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b0 || bus.clr_valid !== 1'b0 ||
            bus.clr_mask !== 32'h0 || bus.claim_id !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b busy=%b clr_valid=%b clr_mask=%h id=%0d, required all 0",
                     bus.cpu_irq, bus.busy, bus.clr_valid, bus.clr_mask, bus.claim_id);
        end
    endtask

    task automatic test_single_pin();
        int c;
        apply_reset();
        bus.irq_status = 32'h10;
        step();
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_arb: irq=%b busy=%b, required irq=0 busy=1", bus.cpu_irq, bus.busy);
        end
        step();
        checks++;
        if (bus.cpu_irq !== 1'b1 || bus.claim_id !== 5'd4) begin
            errors++;
            $display("FAIL single_notify: irq=%b id=%0d, required irq=1 id=4", bus.cpu_irq, bus.claim_id);
        end
        bus.cpu_claim = 1'b1;
        step();
        bus.cpu_claim = 1'b0;
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_claim: irq=%b busy=%b, required irq=0 busy=1", bus.cpu_irq, bus.busy);
        end
        bus.cpu_complete = 1'b1;
        step();
        bus.cpu_complete = 1'b0;
        checks++;
        if (bus.clr_valid !== 1'b1 || bus.clr_mask !== 32'h10) begin
            errors++;
            $display("FAIL single_clear: clr_valid=%b clr_mask=%h, required 1 / 00000010", bus.clr_valid, bus.clr_mask);
        end
        bus.clr_ready = 1'b1;
        step();
        bus.clr_ready  = 1'b0;
        bus.irq_status = 32'h0;
        checks++;
        if (bus.clr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_handshake: clr_valid=%b busy=%b, required 0 / 0", bus.clr_valid, bus.busy);
        end
        // pointer now 5: with pins 4 and 5 pending, pin 5 must win
        bus.irq_status = 32'h30;
        wait_irq(c);
        checks++;
        if (c < 0 || bus.claim_id !== 5'd5) begin
            errors++;
            $display("FAIL single_rr_ptr: wait=%0d id=%0d, required id=5", c, bus.claim_id);
        end
    endtask

    task automatic test_round_robin();
        int c;
        logic [4:0] exp_ids [5];
        exp_ids = '{5'd0, 5'd2, 5'd31, 5'd0, 5'd2};
        apply_reset();
        bus.irq_status = 32'h8000_0005;
        for (int k = 0; k < 5; k++) begin
            wait_irq(c);
            checks++;
            if (c < 0 || bus.claim_id !== exp_ids[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: wait=%0d id=%0d, required id=%0d", k, c, bus.claim_id, exp_ids[k]);
            end
            do_service();
        end
    endtask

    task automatic test_holdoff();
        int c;
        int cnt;
        apply_reset();
        bus.cfg_holdoff = 8'd5;
        bus.irq_status  = 32'h3;
        wait_irq(c);
        checks++;
        if (c != 2 || bus.claim_id !== 5'd0) begin
            errors++;
            $display("FAIL holdoff_first: wait=%0d id=%0d, required wait=2 id=0", c, bus.claim_id);
        end
        do_service();
        cnt = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (bus.cpu_irq === 1'b1) begin
                cnt = i;
                break;
            end
        end
        checks++;
        if (cnt != 7 || bus.claim_id !== 5'd1) begin
            errors++;
            $display("FAIL holdoff_gap: gap=%0d id=%0d, required gap=7 id=1", cnt, bus.claim_id);
        end
    endtask

    task automatic test_withdraw();
        int c;
        apply_reset();
        bus.irq_status = 32'h8;
        wait_irq(c);
        checks++;
        if (c < 0 || bus.claim_id !== 5'd3) begin
            errors++;
            $display("FAIL withdraw_notify: wait=%0d id=%0d, required id=3", c, bus.claim_id);
        end
        bus.cfg_mask = 32'hFFFF_FFF7;
        step();
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b0 || bus.clr_valid !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_drop: irq=%b busy=%b clr_valid=%b, required 0/0/0",
                     bus.cpu_irq, bus.busy, bus.clr_valid);
        end
        // pointer must still be 0, so pin 3 is chosen over pin 4
        bus.cfg_mask   = '1;
        bus.irq_status = 32'h18;
        wait_irq(c);
        checks++;
        if (c < 0 || bus.claim_id !== 5'd3) begin
            errors++;
            $display("FAIL withdraw_rr_ptr: wait=%0d id=%0d, required id=3", c, bus.claim_id);
        end
    endtask

    task automatic test_backpressure();
        int c;
        int bad;
        apply_reset();
        bus.irq_status = 32'h4;
        wait_irq(c);
        bus.cpu_claim = 1'b1;
        step();
        bus.cpu_claim    = 1'b0;
        bus.cpu_complete = 1'b1;
        step();
        bus.cpu_complete = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.cpu_claim    = (i == 3);
            bus.cpu_complete = (i == 5);
            step();
            checks++;
            if (bus.clr_valid !== 1'b1 || bus.clr_mask !== 32'h4 || bus.claim_id !== 5'd2 || bus.cpu_irq !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: clr_valid=%b clr_mask=%h id=%0d irq=%b, required 1/00000004/2/0",
                         i, bus.clr_valid, bus.clr_mask, bus.claim_id, bus.cpu_irq);
            end
        end
        bus.cpu_claim    = 1'b0;
        bus.cpu_complete = 1'b0;
        bus.clr_ready    = 1'b1;
        step();
        bus.irq_status = 32'h0;
        checks++;
        if (bus.clr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: clr_valid=%b busy=%b, required 0/0", bus.clr_valid, bus.busy);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.clr_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        bus.clr_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_single: extra activity cycles=%0d, required 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int c;
        apply_reset();
        bus.irq_status = 32'h60;
        wait_irq(c);
        do_service();
        wait_irq(c);
        checks++;
        if (c < 0 || bus.claim_id !== 5'd6) begin
            errors++;
            $display("FAIL midrst_pre: wait=%0d id=%0d, required id=6", c, bus.claim_id);
        end
        bus.cpu_claim = 1'b1;
        step();
        bus.cpu_claim = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.busy !== 1'b0 || bus.clr_valid !== 1'b0 ||
            bus.clr_mask !== 32'h0 || bus.claim_id !== 5'd0) begin
            errors++;
            $display("FAIL midrst_outputs: irq=%b busy=%b clr_valid=%b clr_mask=%h id=%0d, required all 0",
                     bus.cpu_irq, bus.busy, bus.clr_valid, bus.clr_mask, bus.claim_id);
        end
        wait_irq(c);
        checks++;
        if (c != 2 || bus.claim_id !== 5'd5) begin
            errors++;
            $display("FAIL midrst_rearm: wait=%0d id=%0d, required wait=2 id=5", c, bus.claim_id);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_single_pin();
        test_round_robin();
        test_holdoff();
        test_withdraw();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
